// File: rtl/aes_round_key_scheduler_if.sv
// Round-key read port between the AES round datapath (master) and the
// round-key scheduler (slave). Request/index go one way, a registered
// valid/data/err response comes back one cycle later.
// Optional feature macro: AES_RK_REVERSE_EN adds rk_rev (decryption order).
interface aes_round_key_scheduler_if;
  logic         rk_req;
  logic [3:0]   rk_idx;
`ifdef AES_RK_REVERSE_EN
  logic         rk_rev;
`endif
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_err;

`ifdef AES_RK_REVERSE_EN
  modport master (output rk_req, rk_idx, rk_rev, input rk_valid, rk_data, rk_err);
  modport slave  (input rk_req, rk_idx, rk_rev, output rk_valid, rk_data, rk_err);
`else
  modport master (output rk_req, rk_idx, input rk_valid, rk_data, rk_err);
  modport slave  (input rk_req, rk_idx, output rk_valid, rk_data, rk_err);
`endif
endinterface

// File: rtl/aes_round_key_scheduler.sv
// AES-256 round-key scheduler. On an accepted key_load it starts the key
// expansion engine, stores keys 0-1 straight from the cipher key and keys
// 2-14 from the engine's subkey stream, then serves round keys by index over
// a registered request/valid port. A stream that breaks early aborts to IDLE
// with a sticky exp_err.
// Optional feature macro: AES_RK_REVERSE_EN (rk_rev=1 serves entry[14-rk_idx]).
module aes_round_key_scheduler (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_load,
  input  logic [255:0]             key_in,
  output logic                     key_busy,
  output logic                     keys_ready,
  output logic                     exp_err,
  output logic                     exp_start,
  output logic [255:0]             exp_key,
  input  logic [127:0]             exp_subkey,
  input  logic                     exp_rdy,
  aes_round_key_scheduler_if.slave rk
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  localparam logic [3:0] LAST_CNT   = 4'd12;  // 13 engine subkeys: keys 2..14
  localparam logic [3:0] MAX_IDX    = 4'd14;

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [3:0]   wr_idx;
  logic [3:0]   rd_idx;
  logic [127:0] key_mem [0:14];

  assign key_busy   = (state == ST_START) || (state == ST_CAPTURE);
  assign keys_ready = (state == ST_READY);
  assign wr_idx     = cnt + 4'd2;

  // Sequencing FSM: load acceptance, engine start pulse, capture counting, error flag.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      exp_err   <= 1'b0;
      exp_start <= 1'b0;
      exp_key   <= '0;
    end else begin
      exp_start <= 1'b0;
      case (state)
        ST_IDLE, ST_READY: begin
          if (key_load) begin
            state     <= ST_START;
            exp_start <= 1'b1;
            exp_key   <= key_in;
            exp_err   <= 1'b0;
            cnt       <= 4'd0;
          end
        end
        ST_START: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (exp_rdy) begin
            if (cnt == LAST_CNT) begin
              state <= ST_READY;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            // Stream broke early: abandon it; later engine output is ignored.
            state   <= ST_IDLE;
            exp_err <= 1'b1;
            cnt     <= 4'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Round-key storage: keys 0-1 from the registered key in START, 2-14 from the engine stream.
  // NOTE: the key array has no reset; it is unreadable until READY, which implies a full rewrite.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_START) begin
        key_mem[0] <= exp_key[255:128];
        key_mem[1] <= exp_key[127:0];
      end else if ((state == ST_CAPTURE) && exp_rdy) begin
        key_mem[wr_idx] <= exp_subkey;
      end
    end
  end

  // Read index selection, optionally mirrored for decryption order.
  // NOTE: rd_idx gets a default before any conditional override so no latch is inferred.
  always_comb begin
    rd_idx = rk.rk_idx;
`ifdef AES_RK_REVERSE_EN
    if (rk.rk_rev) rd_idx = MAX_IDX - rk.rk_idx;
`endif
  end

  // Registered read port: one response per request, rejected unless READY and index in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      rk.rk_valid <= 1'b0;
      rk.rk_err   <= 1'b0;
      rk.rk_data  <= '0;
    end else begin
      rk.rk_valid <= rk.rk_req;
      if (rk.rk_req && (state == ST_READY) && (rk.rk_idx <= MAX_IDX)) begin
        rk.rk_err  <= 1'b0;
        rk.rk_data <= key_mem[rd_idx];
      end else begin
        rk.rk_err  <= rk.rk_req;
        rk.rk_data <= '0;
      end
    end
  end

endmodule
